copro_result_buffer: RTL and testbench



---
 rtl/copro_result_buffer.sv | 134 +++++++++++++
 tb/tb_copro_result_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/copro_result_buffer.sv
// Result FIFO between the coprocessor ALU and the CV-X-IF result channel.
// Captures no-backpressure ALU pulses and throttles issue with a credit check.
module copro_result_buffer #(
    parameter int unsigned Depth    = 4,
    parameter int unsigned XLEN     = 32,
    parameter type         hartid_t = logic,
    parameter type         id_t     = logic
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_fire_i,
    output logic            issue_ready_o,
    input  logic            alu_valid_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  hartid_t         alu_hartid_i,
    input  id_t             alu_id_i,
    input  logic [4:0]      alu_rd_i,
    input  logic            alu_we_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_data_o,
    output hartid_t         result_hartid_o,
    output id_t             result_id_o,
    output logic [4:0]      result_rd_o,
    output logic            result_we_o,
    output logic [$clog2(Depth):0] count_o,
    output logic            overflow_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [XLEN-1:0] data;
        hartid_t         hartid;
        id_t             id;
        logic [4:0]      rd;
        logic            we;
    } entry_t;

    entry_t            mem_r [Depth];
    logic [PtrW-1:0]   wr_ptr_r;
    logic [PtrW-1:0]   rd_ptr_r;
    logic [CntW-1:0]   count_r;
    logic              pending_r;
    logic              overflow_r;

    logic              nonempty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              issue_ok_s;
    logic              issue_acc_s;
    logic [CntW:0]     credit_s;
    entry_t            head_s;
    entry_t            wr_entry_s;

    assign nonempty_s  = (count_r != {CntW{1'b0}});
    assign full_s      = (count_r == CntW'(Depth));
    assign pop_s       = nonempty_s & result_ready_i;
    // A pop in the same cycle frees the slot the push lands in, even when full.
    assign push_s      = alu_valid_i & (~full_s | pop_s);
    assign drop_s      = alu_valid_i & full_s & ~pop_s;
    assign credit_s    = {1'b0, count_r} + {{CntW{1'b0}}, pending_r};
    assign issue_ok_s  = (credit_s < (CntW + 1)'(Depth));
    assign issue_acc_s = issue_fire_i & issue_ok_s;
    assign head_s      = mem_r[rd_ptr_r];

    assign wr_entry_s = '{data: alu_result_i, hartid: alu_hartid_i, id: alu_id_i,
                          rd: alu_rd_i, we: alu_we_i};

    // Entry storage; contents are don't-care until written, outputs are gated by count.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    // Pointers, occupancy, in-flight credit and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r   <= {PtrW{1'b0}};
            rd_ptr_r   <= {PtrW{1'b0}};
            count_r    <= {CntW{1'b0}};
            pending_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CntW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CntW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
            if (issue_acc_s) begin
                pending_r <= 1'b1;
            end else if (alu_valid_i) begin
                pending_r <= 1'b0;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Head presentation, forced to zero while empty.
    always_comb begin
        result_data_o   = {XLEN{1'b0}};
        result_hartid_o = '0;
        result_id_o     = '0;
        result_rd_o     = 5'd0;
        result_we_o     = 1'b0;
        if (nonempty_s) begin
            result_data_o   = head_s.data;
            result_hartid_o = head_s.hartid;
            result_id_o     = head_s.id;
            result_rd_o     = head_s.rd;
            result_we_o     = head_s.we;
        end else begin
            result_we_o     = 1'b0;
        end
    end

    assign result_valid_o = nonempty_s;
    assign issue_ready_o  = issue_ok_s;
    assign count_o        = count_r;
    assign overflow_o     = overflow_r;

endmodule

// File: tb/tb_copro_result_buffer.sv
// Cycle-table bench for copro_result_buffer with a scoreboard queue for
// result payloads and hand sequences for async reset mid-operation.
module tb_copro_result_buffer;

    typedef logic [1:0] hart_t;
    typedef logic [3:0] tid_t;

    typedef struct packed {
        logic [31:0] data;
        hart_t       hart;
        tid_t        id;
        logic [4:0]  rd;
        logic        we;
    } sb_t;

    typedef struct {
        logic        fire;
        logic        av;
        logic        rdy;
        logic [31:0] data;
        tid_t        id;
        logic [4:0]  rd;
        logic        we;
        logic        push;
        int          cnt;
        logic        ir;
        logic        ov;
    } row_t;

    logic        clk;
    logic        rst_n;
    logic        issue_fire;
    logic        issue_ready;
    logic        alu_valid;
    logic [31:0] alu_result;
    hart_t       alu_hartid;
    tid_t        alu_id;
    logic [4:0]  alu_rd;
    logic        alu_we;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_data;
    hart_t       result_hartid;
    tid_t        result_id;
    logic [4:0]  result_rd;
    logic        result_we;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    sb_t  sb_q[$];
    row_t rows[$];

    copro_result_buffer #(
        .Depth(4), .XLEN(32), .hartid_t(hart_t), .id_t(tid_t)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_fire_i(issue_fire), .issue_ready_o(issue_ready),
        .alu_valid_i(alu_valid), .alu_result_i(alu_result), .alu_hartid_i(alu_hartid),
        .alu_id_i(alu_id), .alu_rd_i(alu_rd), .alu_we_i(alu_we),
        .result_valid_o(result_valid), .result_ready_i(result_ready),
        .result_data_o(result_data), .result_hartid_o(result_hartid),
        .result_id_o(result_id), .result_rd_o(result_rd), .result_we_o(result_we),
        .count_o(count), .overflow_o(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic row_t mk(input logic fire, input logic av, input logic rdy, input int id,
                                input logic push, input int cnt, input logic ir, input logic ov);
        row_t r;
        r.fire = fire; r.av = av; r.rdy = rdy;
        r.id   = tid_t'(id);
        r.data = 32'h1000_0000 + 32'(id);
        r.rd   = 5'(id) + 5'd1;
        r.we   = r.id[0];
        r.push = push; r.cnt = cnt; r.ir = ir; r.ov = ov;
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(result_valid), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_issue_ready"}, 64'(issue_ready), 64'd1);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_fields_zero"},
              64'({result_data, result_hartid, result_id, result_rd, result_we}), 64'd0);
    endtask

    // One cycle: drive at negedge, compare register-driven outputs, update scoreboard.
    task automatic apply_row(input row_t r, input int idx);
        sb_t e;
        @(negedge clk);
        issue_fire   = r.fire;
        alu_valid    = r.av;
        alu_result   = r.av ? r.data : 32'd0;
        alu_hartid   = r.av ? r.id[1:0] : 2'd0;
        alu_id       = r.av ? r.id : 4'd0;
        alu_rd       = r.av ? r.rd : 5'd0;
        alu_we       = r.av ? r.we : 1'b0;
        result_ready = r.rdy;
        #1;
        check($sformatf("row%0d_count", idx), 64'(count), 64'(r.cnt));
        check($sformatf("row%0d_valid", idx), 64'(result_valid), 64'(r.cnt != 0));
        check($sformatf("row%0d_issue_ready", idx), 64'(issue_ready), 64'(r.ir));
        check($sformatf("row%0d_overflow", idx), 64'(overflow), 64'(r.ov));
        if (r.cnt != 0) begin
            if (sb_q.size() == 0) begin
                check($sformatf("row%0d_sb_nonempty", idx), 64'd0, 64'd1);
            end else begin
                check($sformatf("row%0d_head", idx),
                      64'({result_data, result_hartid, result_id, result_rd, result_we}),
                      64'(sb_q[0]));
                if (r.rdy) void'(sb_q.pop_front());
            end
        end else begin
            check($sformatf("row%0d_fields_zero", idx),
                  64'({result_data, result_hartid, result_id, result_rd, result_we}), 64'd0);
        end
        if (r.push) begin
            e = '{data: r.data, hart: r.id[1:0], id: r.id, rd: r.rd, we: r.we};
            sb_q.push_back(e);
        end
    endtask

    initial begin
        row_t r;
        rst_n = 1'b0;
        issue_fire = 1'b0; alu_valid = 1'b0; alu_result = 32'd0; alu_hartid = 2'd0;
        alu_id = 4'd0; alu_rd = 5'd0; alu_we = 1'b0; result_ready = 1'b0;

        // Reset, then single op with ready held high.
        rows.push_back(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0));
        r = mk(1'b0, 1'b1, 1'b1, 3, 1'b1, 0, 1'b1, 1'b0);
        r.data = 32'h0000_00A5; r.rd = 5'd7; r.we = 1'b1;
        rows.push_back(r);
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 1, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0));
        // Fill with back-to-back issue, ready low.
        rows.push_back(mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, 1, 1'b1, 1, 1'b1, 1'b0));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, 2, 1'b1, 2, 1'b1, 1'b0));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, 3, 1'b1, 3, 1'b0, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 4, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 4, 1'b0, 1'b0));
        // Drain from full.
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 4, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 3, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 2, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 1, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0));
        // Refill, then push and pop together while full.
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 4, 1'b1, 0, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 5, 1'b1, 1, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 6, 1'b1, 2, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 7, 1'b1, 3, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 9, 1'b1, 4, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 4, 1'b0, 1'b0));
        // Forced overflow: entry dropped, head unchanged, flag sticky.
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 15, 1'b0, 4, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 4, 1'b0, 1'b1));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 4, 1'b0, 1'b1));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 3, 1'b1, 1'b1));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 2, 1'b1, 1'b1));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 1, 1'b1, 1'b1));
        rows.push_back(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1));
        // Leave an entry and a pending credit in flight before reset.
        rows.push_back(mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, 10, 1'b1, 0, 1'b1, 1'b1));

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle_outputs("after_reset");

        for (int i = 0; i < rows.size(); i++) begin
            apply_row(rows[i], i);
        end

        // Asynchronous reset mid-operation: outputs must clear without a clock edge.
        @(negedge clk);
        issue_fire = 1'b0; alu_valid = 1'b0; result_ready = 1'b0;
        #1;
        check("pre_reset_count", 64'(count), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Stale pending would make issue_ready drop at count 3.
        rows.delete();
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 11, 1'b1, 0, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 12, 1'b1, 1, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 13, 1'b1, 2, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 3, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 2, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 1, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0));
        for (int i = 0; i < rows.size(); i++) begin
            apply_row(rows[i], 100 + i);
        end
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
